// File: rtl/sprite_render_engine.sv
// rtl/sprite_render_engine.sv - sprite draw/erase scanner feeding per-pixel VGA writes
//
// Purpose:
//   Services one held draw or erase request at a time for one of four objects
//   (player, enemy1..3). It latches the object's position and scans the
//   SPRITE_W x SPRITE_H box in row-major order, addressing the sprite ROM one
//   pixel per cycle. It then plots each on-screen pixel and pulses erased/loaded
//   for one cycle when the operation has finished.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   req_draw    in   [3:0] level draw request per object (bit0 player)
//   req_erase   in   [3:0] level erase request per object
//   obj_x       in   [31:0] packed 8-bit x per object
//   obj_y       in   [27:0] packed 7-bit y per object
//   rom_addr    out  {obj_sel, pixel_index} sprite ROM read address
//   rom_data    in   ROM pixel colour, valid one cycle after rom_addr
//   vga_x/vga_y out  pixel coordinates
//   vga_colour  out  pixel colour
//   vga_plot    out  write strobe for vga_x/vga_y/vga_colour
//   erased      out  [3:0] one-cycle done pulse, erase operation
//   loaded      out  [3:0] one-cycle done pulse, draw operation
//   busy        out  high whenever the engine is not idle
//
// Configuration macro:
//   TRANSPARENT_EN - when defined, draw pixels whose ROM colour equals
//                    TRANSPARENT_KEY are not plotted.

module sprite_render_engine #(
    parameter int               SPRITE_W        = 8,
    parameter int               SPRITE_H        = 8,
    parameter int               COLOUR_W        = 3,
    parameter logic [COLOUR_W-1:0] BG_COLOUR    = 3'b000,
    parameter int               SCREEN_W        = 160,
    parameter int               SCREEN_H        = 120,
    parameter logic [COLOUR_W-1:0] TRANSPARENT_KEY = 3'b101
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [3:0]                                req_draw,
    input  logic [3:0]                                req_erase,
    input  logic [31:0]                               obj_x,
    input  logic [27:0]                               obj_y,
    output logic [$clog2(SPRITE_W*SPRITE_H)+1:0]      rom_addr,
    input  logic [COLOUR_W-1:0]                       rom_data,
    output logic [7:0]                                vga_x,
    output logic [6:0]                                vga_y,
    output logic [COLOUR_W-1:0]                       vga_colour,
    output logic                                      vga_plot,
    output logic [3:0]                                erased,
    output logic [3:0]                                loaded,
    output logic                                      busy
);

    localparam int N     = SPRITE_W * SPRITE_H;
    localparam int IDX_W = $clog2(N);

`ifdef TRANSPARENT_EN
    localparam bit TRANSP_ON = 1'b1;
`else
    localparam bit TRANSP_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              erase_q, erase_d;
    logic [1:0]        sel_q, sel_d;
    logic [7:0]        base_x_q, base_x_d;
    logic [6:0]        base_y_q, base_y_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              flush_q, flush_d;

    // Stage 1: screen coordinates of the pixel whose ROM read is in flight.
    logic              s1_valid_q;
    logic [8:0]        s1_px_q, s1_py_q;

    // Stage 2: registered VGA outputs, aligned with the returning ROM data.
    logic [7:0]        vga_x_q;
    logic [6:0]        vga_y_q;
    logic [COLOUR_W-1:0] vga_colour_q;
    logic              vga_plot_q;

    logic [7:0]        xs [4];
    logic [6:0]        ys [4];
    logic [8:0]        cx_w, cy_w;
    logic              transparent;

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            xs[i] = obj_x[8*i +: 8];
            ys[i] = obj_y[7*i +: 7];
        end
    end

    assign cx_w = 9'(32'(idx_q) % SPRITE_W);
    assign cy_w = 9'(32'(idx_q) / SPRITE_W);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            erase_q  <= 1'b0;
            sel_q    <= 2'd0;
            base_x_q <= 8'd0;
            base_y_q <= 7'd0;
            idx_q    <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            erase_q  <= erase_d;
            sel_q    <= sel_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            idx_q    <= idx_d;
            flush_q  <= flush_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        erase_d  = erase_q;
        sel_d    = sel_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        idx_d    = idx_q;
        flush_d  = flush_q;
        erased   = 4'b0000;
        loaded   = 4'b0000;
        busy     = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (|req_erase || |req_draw) begin
                    // Erase has priority so an erase->draw pair on the same
                    // object clears the old image before the new one appears.
                    erase_d  = |req_erase;
                    sel_d    = (|req_erase) ? lowest_set(req_erase) : lowest_set(req_draw);
                    base_x_d = xs[sel_d];
                    base_y_d = ys[sel_d];
                    idx_d    = '0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_d   = '0;
                    flush_d = 1'b0;
                    state_d = ST_FLUSH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                // Two cycles: the last address drains through stage 1, then
                // the last pixel sits on the VGA outputs.
                if (flush_q) begin
                    flush_d = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    flush_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (erase_q) erased[sel_q] = 1'b1;
                else         loaded[sel_q] = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rom_addr = {sel_q, idx_q};

    // ---------------------------------------------------------- pixel pipe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_px_q    <= 9'd0;
            s1_py_q    <= 9'd0;
        end else begin
            s1_valid_q <= (state_q == ST_SCAN);
            s1_px_q    <= {1'b0, base_x_q} + cx_w;
            s1_py_q    <= {2'b00, base_y_q} + cy_w;
        end
    end

    assign transparent = TRANSP_ON && !erase_q && (rom_data == TRANSPARENT_KEY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            vga_x_q      <= s1_px_q[7:0];
            vga_y_q      <= s1_py_q[6:0];
            vga_colour_q <= erase_q ? BG_COLOUR : rom_data;
            // Off-screen pixels still take their slot; only the strobe is dropped.
            vga_plot_q   <= s1_valid_q
                            && (s1_px_q < 9'(SCREEN_W))
                            && (s1_py_q < 9'(SCREEN_H))
                            && !transparent;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_sprite_render_engine.sv
// tb/tb_sprite_render_engine.sv - randomized self-checking bench for sprite_render_engine

module tb_sprite_render_engine;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int SW = 160;
    localparam int SH = 120;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_draw = 4'b0;
    logic [3:0]  req_erase = 4'b0;
    logic [31:0] obj_x = 32'b0;
    logic [27:0] obj_y = 28'b0;
    logic [7:0]  rom_addr;
    logic [2:0]  rom_data = 3'b0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [3:0]  erased;
    logic [3:0]  loaded;
    logic        busy;

    logic [2:0]  rom_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    sprite_render_engine dut (
        .clock      (clock),
        .reset      (reset),
        .req_draw   (req_draw),
        .req_erase  (req_erase),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .erased     (erased),
        .loaded     (loaded),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Synchronous sprite ROM: data follows the address by one clock.
    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called just after a negedge with requests set up; the next posedge is
    // the edge at which the engine samples them (cycle 0).
    task automatic run_op(input bit drop_erase_only, output int nobs);
        bit          m_erase;
        logic [3:0]  vec;
        int          m_sel, bx, by, px, py, k, nexp;
        logic        e_plot [N];
        int          e_x [N];
        int          e_y [N];
        int          e_c [N];
        logic [3:0]  exp_done;
        bit          exp_p;

        m_erase = (req_erase != 4'b0);
        vec     = m_erase ? req_erase : req_draw;
        m_sel   = -1;
        for (int i = 0; i < 4; i++)
            if (m_sel < 0 && vec[i]) m_sel = i;
        bx = int'(obj_x[m_sel*8 +: 8]);
        by = int'(obj_y[m_sel*7 +: 7]);

        nexp = 0;
        for (int j = 0; j < N; j++) begin
            px = bx + (j % W);
            py = by + (j / W);
            e_x[j] = px % 256;
            e_y[j] = py % 128;
            e_c[j] = m_erase ? 0 : int'(rom_mem[m_sel*N + j]);
            e_plot[j] = (px < SW) && (py < SH);
`ifdef TRANSPARENT_EN
            if (!m_erase && rom_mem[m_sel*N + j] == 3'b101) e_plot[j] = 1'b0;
`endif
            if (e_plot[j]) nexp++;
        end

        nobs = 0;
        for (int c = 0; c <= N + 3; c++) begin
            @(negedge clock);
            // Position inputs must have been latched at cycle 0.
            if (c == 5) begin
                obj_x = $urandom;
                obj_y = 28'($urandom);
            end
            k = c - 2;
            exp_p = (k >= 0 && k < N) ? e_plot[k] : 1'b0;
            check("plot", 32'(vga_plot), 32'(exp_p));
            if (vga_plot) nobs++;
            if (exp_p) begin
                check("vga_x", 32'(vga_x), 32'(e_x[k]));
                check("vga_y", 32'(vga_y), 32'(e_y[k]));
                check("colour", 32'(vga_colour), 32'(e_c[k]));
            end
            if (c < N) check("rom_addr", 32'(rom_addr), 32'(m_sel * N + c));
            exp_done = (c == N + 2) ? 4'(1 << m_sel) : 4'b0;
            check("erased", 32'(erased), m_erase ? 32'(exp_done) : 32'd0);
            check("loaded", 32'(loaded), m_erase ? 32'd0 : 32'(exp_done));
            check("busy", 32'(busy), (c <= N + 2) ? 32'd1 : 32'd0);
            if (c == N + 2) begin
                req_erase = 4'b0;
                if (!drop_erase_only) req_draw = 4'b0;
            end
        end
        check("plot_count", 32'(nobs), 32'(nexp));
    endtask

    int nobs;

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 3'(i);

        #1 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst_plot", 32'(vga_plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'({erased, loaded}), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_xy", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Player draw at (10,20): whole sprite on screen.
        req_draw = 4'b0001;
        obj_x[7:0] = 8'd10;
        obj_y[6:0] = 7'd20;
        run_op(1'b0, nobs);
        check("t1_count", 32'(nobs), 32'd64);

        // Enemy2 erase at (40,50).
        req_erase = 4'b0100;
        obj_x[23:16] = 8'd40;
        obj_y[20:14] = 7'd50;
        run_op(1'b0, nobs);
        check("t2_count", 32'(nobs), 32'd64);

        // Bottom-right corner clipping.
        req_draw = 4'b0001;
        obj_x[7:0] = 8'd156;
        obj_y[6:0] = 7'd116;
        run_op(1'b0, nobs);
        check("t3_count", 32'(nobs), 32'd16);

        // Erase and draw together: erase first, draw follows back-to-back.
        req_erase = 4'b0001;
        req_draw  = 4'b0001;
        obj_x[7:0] = 8'd30;
        obj_y[6:0] = 7'd40;
        run_op(1'b1, nobs);
        check("t4_erase_count", 32'(nobs), 32'd64);
        check("t4_draw_held", 32'(req_draw), 32'd1);
        run_op(1'b0, nobs);

        // Reset in the middle of a draw.
        req_draw = 4'b0010;
        obj_x[15:8] = 8'd5;
        obj_y[13:7] = 7'd5;
        for (int c = 0; c < 30; c++) @(negedge clock);
        check("t5_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_plot", 32'(vga_plot), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_addr", 32'(rom_addr), 32'd0);
        req_draw = 4'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clock);
            check("t5_no_loaded", 32'(loaded), 32'd0);
            check("t5_idle", 32'(busy), 32'd0);
        end
        req_draw = 4'b1000;
        obj_x[31:24] = 8'd100;
        obj_y[27:21] = 7'd60;
        run_op(1'b0, nobs);
        check("t5_restart_count", 32'(nobs), 32'd64);

`ifdef TRANSPARENT_EN
        for (int i = 0; i < N; i++) rom_mem[i] = 3'b101;
        rom_mem[0] = 3'b011;
        req_draw = 4'b0001;
        obj_x[7:0] = 8'd10;
        obj_y[6:0] = 7'd20;
        run_op(1'b0, nobs);
        check("t6_draw_count", 32'(nobs), 32'd1);
        req_erase = 4'b0001;
        run_op(1'b0, nobs);
        check("t6_erase_count", 32'(nobs), 32'd64);
`endif

        // Randomized operations.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 256; i++) rom_mem[i] = 3'($urandom);
            req_erase = 4'($urandom_range(0, 15));
            req_draw  = 4'($urandom_range(0, 15));
            if (r % 3 == 0) req_erase = 4'b0;
            if (req_erase == 4'b0 && req_draw == 4'b0) req_draw = 4'b0100;
            obj_x = $urandom;
            obj_y = 28'($urandom);
            run_op(1'b0, nobs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
